// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants, store-size encodings and loader states for dmem_responder.
package dmem_pkg;
    localparam int DMEM_DEPTH = 256;
    localparam logic [1:0] WS_BYTE = 2'b00;
    localparam logic [1:0] WS_HALF = 2'b01;
    localparam logic [1:0] WS_WORD = 2'b10;
    localparam logic [1:0] WS_RSVD = 2'b11;
    typedef enum logic [1:0] {HDR_SP, HDR_CNT, DATA, DONE} ld_state_e;
endpackage

// File: rtl/dmem_loader.sv
// dmem_loader: consumes the image stream (SP, count, data words) and emits memory fill writes.
module dmem_loader
    import dmem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_ld_valid,
    input  logic [31:0] i_ld_data,
    output logic        o_ld_ready,
    output logic        o_load_done,
    output logic [31:0] o_sp_init,
    output logic        o_we,
    output logic [7:0]  o_idx,
    output logic [31:0] o_data
);
    ld_state_e   r_state, w_next;
    logic [31:0] r_cnt, r_idx, r_sp;
    logic        w_xfer;

    assign o_ld_ready  = r_state != DONE;
    assign o_load_done = r_state == DONE;
    assign o_sp_init   = r_sp;
    assign w_xfer      = i_ld_valid & o_ld_ready;
    // Words past the array depth are still accepted so the stream drains.
    assign o_we        = w_xfer && r_state == DATA && r_idx < 32'(DMEM_DEPTH);
    assign o_idx       = r_idx[7:0];
    assign o_data      = i_ld_data;

    always_comb begin
        w_next = r_state;
        case (r_state)
            HDR_SP:  w_next = w_xfer ? HDR_CNT : HDR_SP;
            HDR_CNT: w_next = !w_xfer ? HDR_CNT : (i_ld_data == 32'd0) ? DONE : DATA;
            DATA:    w_next = (w_xfer && r_idx + 32'd1 == r_cnt) ? DONE : DATA;
            default: w_next = DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= HDR_SP;
            r_sp    <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_next;
            if (w_xfer && r_state == HDR_SP) r_sp <= i_ld_data;
            if (w_xfer && r_state == HDR_CNT) begin
                r_cnt <= i_ld_data;
                r_idx <= '0;
            end
            if (w_xfer && r_state == DATA) r_idx <= r_idx + 32'd1;
        end
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: image-loaded 256x32 big-endian data memory with lane writes and misalignment trap.
// Define DMEM_WRITE_FIRST_EN to make same-word read/write return the newly merged value.
module dmem_responder
    import dmem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    output logic        load_done,
    output logic [31:0] sp_init,
    input  logic [9:0]  RAddr_d,
    output logic [31:0] Rdata_d,
    input  logic        Wen,
    input  logic [1:0]  WSize,
    input  logic [9:0]  WAddr_d,
    input  logic [31:0] Wdata_d,
    output logic        err_misalign,
    output logic [9:0]  err_addr
);
    logic [31:0] r_mem [DMEM_DEPTH];
    logic [31:0] r_rdata;
    logic        r_err;
    logic [9:0]  r_err_addr;
    logic        w_lwe, w_bad, w_wact, w_err, w_pwe, w_unused;
    logic [7:0]  w_lidx, w_widx, w_ridx;
    logic [31:0] w_ldata, w_mask, w_wval, w_merged, w_rd;
    logic [4:0]  w_shift;

    dmem_loader u_loader (
        .clk         (clk),
        .rst         (rst),
        .i_ld_valid  (ld_valid),
        .i_ld_data   (ld_data),
        .o_ld_ready  (ld_ready),
        .o_load_done (load_done),
        .o_sp_init   (sp_init),
        .o_we        (w_lwe),
        .o_idx       (w_lidx),
        .o_data      (w_ldata)
    );

    assign w_unused = &{1'b0, RAddr_d[1:0]};
    assign w_widx   = WAddr_d[9:2];
    assign w_ridx   = RAddr_d[9:2];
    assign w_shift  = {WAddr_d[1:0], 3'b000};
    // Big-endian: offset 0 is the most significant lane.
    assign w_mask   = (WSize == WS_BYTE) ? 32'hFF00_0000 >> w_shift :
                      (WSize == WS_HALF) ? 32'hFFFF_0000 >> w_shift : 32'hFFFF_FFFF;
    assign w_wval   = (WSize == WS_BYTE) ? {Wdata_d[7:0], 24'h0} >> w_shift :
                      (WSize == WS_HALF) ? {Wdata_d[15:0], 16'h0} >> w_shift : Wdata_d;
    assign w_bad    = (WSize == WS_RSVD) || (WSize == WS_HALF && WAddr_d[0]) ||
                      (WSize == WS_WORD && WAddr_d[1:0] != 2'b00);
    assign w_wact   = load_done & Wen;
    assign w_err    = w_wact & w_bad;
    assign w_pwe    = w_wact & ~w_bad;
    assign w_merged = (r_mem[w_widx] & ~w_mask) | (w_wval & w_mask);
`ifdef DMEM_WRITE_FIRST_EN
    assign w_rd     = (w_pwe && w_widx == w_ridx) ? w_merged : r_mem[w_ridx];
`else
    assign w_rd     = r_mem[w_ridx];
`endif
    assign Rdata_d      = r_rdata;
    assign err_misalign = r_err;
    assign err_addr     = r_err_addr;

    // Contents survive reset so a reload only overwrites what the new image covers.
    always_ff @(posedge clk) begin
        if (w_lwe) r_mem[w_lidx] <= w_ldata;
        else if (w_pwe) r_mem[w_widx] <= w_merged;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end else begin
            r_rdata <= load_done ? w_rd : 32'h0;
            if (w_err && !r_err) begin
                r_err      <= 1'b1;
                r_err_addr <= WAddr_d;
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for image load, lane writes, error trap and reload.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_data = '0;
    logic        ld_ready, load_done, err_misalign;
    logic [31:0] sp_init, Rdata_d;
    logic [9:0]  RAddr_d = '0, WAddr_d = '0, err_addr;
    logic        Wen = 1'b0;
    logic [1:0]  WSize = 2'b00;
    logic [31:0] Wdata_d = '0;

    logic [31:0] m [256];
    logic [31:0] sb_q [$];
    logic [31:0] img [$];
    int n_chk = 0, n_pass = 0, xfers = 0;

    always #5 clk = ~clk;

    dmem_responder dut (
        .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .load_done(load_done), .sp_init(sp_init), .RAddr_d(RAddr_d), .Rdata_d(Rdata_d),
        .Wen(Wen), .WSize(WSize), .WAddr_d(WAddr_d), .Wdata_d(Wdata_d),
        .err_misalign(err_misalign), .err_addr(err_addr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [31:0] lane_write(input logic [31:0] o, input logic [1:0] sz,
                                               input logic [9:0] a, input logic [31:0] d);
        if (sz == 2'b00) begin
            case (a[1:0])
                2'd0: return {d[7:0], o[23:0]};
                2'd1: return {o[31:24], d[7:0], o[15:0]};
                2'd2: return {o[31:16], d[7:0], o[7:0]};
                default: return {o[31:8], d[7:0]};
            endcase
        end
        if (sz == 2'b01) return a[1] ? {o[31:16], d[15:0]} : {d[15:0], o[15:0]};
        return d;
    endfunction

    function automatic bit is_bad(input logic [1:0] sz, input logic [9:0] a);
        return sz == 2'b11 || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    endfunction

    task automatic op(input logic we, input logic [1:0] sz, input logic [9:0] wa,
                      input logic [31:0] wd, input logic [9:0] ra, input string tag);
        logic [31:0] nv;
        logic        hit;
        Wen = we; WSize = sz; WAddr_d = wa; Wdata_d = wd; RAddr_d = ra;
        nv  = lane_write(m[wa[9:2]], sz, wa, wd);
        hit = we && !is_bad(sz, wa) && wa[9:2] == ra[9:2];
`ifdef DMEM_WRITE_FIRST_EN
        sb_q.push_back(hit ? nv : m[ra[9:2]]);
`else
        sb_q.push_back(m[ra[9:2]]);
`endif
        if (we && !is_bad(sz, wa)) m[wa[9:2]] = nv;
        @(negedge clk);
        Wen = 1'b0;
        chk(tag, Rdata_d, sb_q.pop_front());
    endtask

    task automatic rd(input logic [9:0] ra, input string tag);
        op(1'b0, 2'b00, 10'd0, 32'd0, ra, tag);
    endtask

    task automatic send(input logic [31:0] w);
        for (int i = 0; i < 20 && !ld_ready; i++) @(negedge clk);
        if (ld_ready) xfers++;
        ld_valid = 1'b1;
        ld_data  = w;
        @(negedge clk);
        ld_valid = 1'b0;
    endtask

    task automatic load(input logic [31:0] sp, input string tag);
        int cnt;
        cnt   = img.size();
        xfers = 0;
        send(sp);
        if (cnt == 0) chk({tag, "_busy"}, {31'b0, load_done}, 32'd0);
        send(32'(cnt));
        for (int i = 0; i < cnt; i++) begin
            if (i < 256) m[i] = img[i];
            if (i == cnt - 1) chk({tag, "_busy"}, {31'b0, load_done}, 32'd0);
            send(img[i]);
        end
        chk({tag, "_xfers"}, 32'(xfers), 32'(cnt + 2));
        chk({tag, "_done"}, {31'b0, load_done}, 32'd1);
        chk({tag, "_sp"}, sp_init, sp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        do_reset();
        chk("rst_ready", {31'b0, ld_ready}, 32'd1);
        chk("rst_done", {31'b0, load_done}, 32'd0);
        chk("rst_sp", sp_init, 32'd0);
        chk("rst_rdata", Rdata_d, 32'd0);
        chk("rst_err", {31'b0, err_misalign}, 32'd0);
        chk("rst_erraddr", {22'b0, err_addr}, 32'd0);

        img = {32'h1122_3344, 32'hAABB_CCDD};
        load(32'h0000_0400, "img1");
        rd(10'd4, "rd4");
        rd(10'd0, "rd0");
        rd(10'd7, "rd7_lowbits");

        op(1'b1, 2'b00, 10'd1, 32'hFFFF_FF5A, 10'd0, "sb1");
        rd(10'd0, "sb1_rd");
        op(1'b1, 2'b01, 10'd2, 32'h0000_BEEF, 10'd0, "sh2");
        rd(10'd0, "sh2_rd");
        op(1'b1, 2'b00, 10'd7, 32'h0000_0077, 10'd4, "sb7");
        op(1'b1, 2'b01, 10'd4, 32'h0000_1234, 10'd4, "sh4");
        rd(10'd4, "sh4_rd");
        chk("lanes_w0", m[0], 32'h115A_BEEF);
        chk("lanes_w1", m[1], 32'h1234_CC77);

        op(1'b1, 2'b10, 10'd8, 32'h0102_0304, 10'd0, "sw8");
        op(1'b1, 2'b10, 10'd8, 32'hCAFE_F00D, 10'd8, "same_cycle");
        rd(10'd8, "sw8_rd");

        op(1'b1, 2'b10, 10'd6, 32'h9999_9999, 10'd4, "sw6_mis");
        rd(10'd4, "sw6_unchanged");
        chk("err_set", {31'b0, err_misalign}, 32'd1);
        chk("err_addr6", {22'b0, err_addr}, 32'd6);
        op(1'b1, 2'b01, 10'd3, 32'h0000_7777, 10'd0, "sh3_mis");
        rd(10'd0, "sh3_unchanged");
        chk("err_addr_held", {22'b0, err_addr}, 32'd6);
        op(1'b1, 2'b11, 10'd8, 32'h5555_5555, 10'd8, "rsvd");
        rd(10'd8, "rsvd_unchanged");

        do_reset();
        chk("rst2_err", {31'b0, err_misalign}, 32'd0);
        chk("rst2_erraddr", {22'b0, err_addr}, 32'd0);
        img = {};
        load(32'h0000_0055, "cnt0");
        rd(10'd0, "cnt0_mem_kept");

        do_reset();
        img = {};
        for (int i = 0; i < 300; i++) img.push_back(32'h1000_0000 + 32'(i));
        load(32'h0000_0300, "cnt300");
        rd(10'd0, "cnt300_i0");
        rd(10'd176, "cnt300_i44");
        rd(10'd1020, "cnt300_i255");

        do_reset();
        RAddr_d = 10'd0;
        send(32'h0000_0111);
        send(32'd5);
        for (int i = 0; i < 3; i++) begin
            m[i] = 32'hA000_0000 + 32'(i);
            send(m[i]);
        end
        chk("midload_rdata", Rdata_d, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("reload_ready", {31'b0, ld_ready}, 32'd1);
        chk("reload_done", {31'b0, load_done}, 32'd0);
        Wen = 1'b1; WSize = 2'b10; WAddr_d = 10'h03C; Wdata_d = 32'hDEAD_0000;
        send(32'h0000_0222);
        chk("reload_sp", sp_init, 32'h0000_0222);
        send(32'd2);
        WAddr_d = 10'h03E;
        m[0] = 32'hB000_0000;
        m[1] = 32'hB000_0001;
        send(m[0]);
        send(m[1]);
        Wen = 1'b0;
        chk("reload_done2", {31'b0, load_done}, 32'd1);
        chk("reload_err", {31'b0, err_misalign}, 32'd0);
        rd(10'h03C, "wen_ignored");
        rd(10'd0, "reload_i0");
        rd(10'd8, "reload_i2_kept");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on posedge clk.
REQ-002 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-003 SHALL have port ld_valid, input, 1, image word valid from loader source.
REQ-004 SHALL have port ld_data, input, 32, image word: SP, then count, then data words.
REQ-005 SHALL have port ld_ready, output, 1, block accepts ld_data this cycle.
REQ-006 SHALL have port load_done, output, 1, image fully loaded; pipeline accesses enabled.
REQ-007 SHALL have port sp_init, output, 32, first image word; the initial $29 value.
REQ-008 SHALL have port RAddr_d, input, 10, byte read address.
REQ-009 SHALL have port Rdata_d, output, 32, read data, big-endian word.
REQ-010 SHALL have port Wen, input, 1, write enable.
REQ-011 SHALL have port WSize, input, 2, 2'b00 byte, 2'b01 half, 2'b10 word, 2'b11 reserved.
REQ-012 SHALL have port WAddr_d, input, 10, byte write address.
REQ-013 SHALL have port Wdata_d, input, 32, store data; size-aligned in the low bits.
REQ-014 SHALL have port err_misalign, output, 1, sticky misaligned- or reserved-size-write flag.
REQ-015 SHALL have port err_addr, output, 10, WAddr_d of the first erroneous write.

Function
REQ-016 SHALL hold 256 x 32-bit words, indexed by address[9:2].
REQ-017 SHALL run the loader FSM through states HDR_SP -> HDR_CNT -> DATA -> DONE; a word transfers on ld_valid & ld_ready.
REQ-018 SHALL drive ld_ready high in HDR_SP, HDR_CNT, and DATA, and low in DONE.
REQ-019 SHALL latch sp_init in HDR_SP, and latch count in HDR_CNT then go to DATA, or to DONE when count==0.
REQ-020 SHALL, in DATA, write word i to memory index i for i < 256; words with i >= 256 are accepted and discarded; go to DONE after count words.
REQ-021 SHALL assert load_done in the cycle after the final transfer.
REQ-022 SHALL ignore Wen and drive Rdata_d=0 while load_done=0.
REQ-023 SHALL register reads: Rdata_d = mem[RAddr_d[9:2]] one cycle after RAddr_d is sampled; RAddr_d[1:0] ignored.
REQ-024 SHALL write only the addressed byte lanes, big-endian: a byte at offset k updates bits [31-8k -: 8]; a half at offset 0 updates [31:16], at offset 2 updates [15:0].
REQ-025 SHALL treat a write as erroneous when it is a half with WAddr_d[0]=1, a word with WAddr_d[1:0]!=0, or WSize=2'b11; an erroneous write is suppressed.
REQ-026 SHALL set err_misalign on the first erroneous write and capture err_addr from that write only; both are held until reset.

Reset
REQ-027 SHALL on rst: FSM to HDR_SP, ld_ready=1, load_done=0, sp_init=0, Rdata_d=0, err_misalign=0, err_addr=0.
REQ-028 SHALL not clear memory contents on rst; a reset mid-load restarts from HDR_SP, and words from the new image overwrite.

Configuration
REQ-029 SHALL with DMEM_WRITE_FIRST_EN defined: when a read and a write hit the same word index in one cycle, Rdata_d returns the lane-merged new value.
REQ-030 SHALL without DMEM_WRITE_FIRST_EN: in that same case, Rdata_d returns the old value.

Structure
REQ-031 SHALL place WSize encodings, DMEM_DEPTH=256, and the loader state enum in package dmem_pkg.
REQ-032 SHALL implement the loader FSM as sub-module dmem_loader; the memory array and error logic stay in dmem_responder.

Verification
REQ-033 SHALL verify: load image 0x00000400, 2, 0x11223344, 0xAABBCCDD -> sp_init=0x400, load_done after 4 transfers, read addr 4 gives 0xAABBCCDD the next cycle.
REQ-034 SHALL verify: SB 0x5A at addr 1 over 0x11223344 -> read addr 0 gives 0x115A3344; SH 0xBEEF at addr 2 -> 0x115ABEEF.
REQ-035 SHALL verify: SW at addr 6 -> memory unchanged, err_misalign=1, err_addr=6; a later SH at addr 3 leaves err_addr=6.
REQ-036 SHALL verify: count=0 -> load_done one cycle after the count word; count=300 -> 300 data words accepted, indices 0..255 written.
REQ-037 SHALL verify: same-cycle SW 0xCAFEF00D and read at addr 8 -> 0xCAFEF00D with DMEM_WRITE_FIRST_EN, prior value without it.
REQ-038 SHALL verify: rst asserted after 3 data words -> ld_ready=1, load_done=0, next accepted word becomes the new sp_init, and Wen is ignored until reload completes.
